// File: rtl/lsu.sv
// Load/store unit: single-outstanding req/ack bus master with lane steering,
// load extension, misalignment detection and a bus-timeout access fault.
module lsu #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  MemRW,
   input  logic [2:0]  Funct3,
   input  logic [31:0] IEUAdr,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic        Stall,
   output logic        LoadMisaligned,
   output logic        StoreMisaligned,
   output logic        AccessFault,
   output logic        BusReq,
   output logic        BusWrite,
   output logic [31:0] BusAdr,
   output logic [3:0]  BusByteEn,
   output logic [31:0] BusWData,
   input  logic        BusAck,
   input  logic [31:0] BusRData
);

   localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state, next;

   logic          isload, isstore, access, aligned;
   logic          launch, timeout, fault_q;
   logic [CW-1:0] cnt;
   logic [3:0]    be_n;
   logic [31:0]   wd_n, rdata;
   logic [2:0]    f3_q;
   logic [1:0]    lo_q;
   logic [7:0]    lane_b;
   logic [15:0]   lane_h;

   assign isload  = (MemRW == 2'b10);
   assign isstore = (MemRW == 2'b01);
   assign access  = isload | isstore;

   always_comb begin
      aligned = 1'b1;
      unique case (Funct3[1:0])
         2'b00:   aligned = 1'b1;
         2'b01:   aligned = ~IEUAdr[0];
         default: aligned = (IEUAdr[1:0] == 2'b00);
      endcase
   end

   assign launch  = (state == IDLE) & access & aligned;
   assign timeout = (state == BUSY) & ~BusAck
                  & (cnt == CW'(TIMEOUT - 1));

   always_comb begin
      be_n = 4'b1111;
      wd_n = WriteData;
      unique case (Funct3[1:0])
         2'b00: begin
            be_n = 4'b0001 << IEUAdr[1:0];
            wd_n = {4{WriteData[7:0]}};
         end
         2'b01: begin
            be_n = 4'b0011 << {IEUAdr[1], 1'b0};
            wd_n = {2{WriteData[15:0]}};
         end
         default: begin
            be_n = 4'b1111;
            wd_n = WriteData;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= next;
   end

   always_comb begin
      next = state;
      unique case (state)
         IDLE:    if (launch) next = BUSY;
         BUSY:    if (BusAck | timeout) next = DONE;
         DONE:    next = IDLE;
         default: next = IDLE;
      endcase
   end

   always_comb begin
      Stall           = 1'b0;
      LoadMisaligned  = 1'b0;
      StoreMisaligned = 1'b0;
      if (reset) begin
         unique case (state)
            IDLE: begin
               Stall           = access & aligned;
               LoadMisaligned  = isload & ~aligned;
               StoreMisaligned = isstore & ~aligned;
            end
            BUSY:    Stall = 1'b1;
            default: Stall = 1'b0;
         endcase
      end
   end

   assign AccessFault = fault_q;

   // Bus outputs only change on launch, so they stay stable through BUSY.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         BusReq    <= 1'b0;
         BusWrite  <= 1'b0;
         BusAdr    <= '0;
         BusByteEn <= '0;
         BusWData  <= '0;
         rdata     <= '0;
         f3_q      <= '0;
         lo_q      <= '0;
         cnt       <= '0;
         fault_q   <= 1'b0;
      end else begin
         fault_q <= timeout;
         if (launch) begin
            BusReq    <= 1'b1;
            BusWrite  <= isstore;
            BusAdr    <= {IEUAdr[31:2], 2'b00};
            BusByteEn <= be_n;
            BusWData  <= wd_n;
            f3_q      <= Funct3;
            lo_q      <= IEUAdr[1:0];
            cnt       <= '0;
         end else if (state == BUSY) begin
            if (BusAck) begin
               BusReq <= 1'b0;
               if (!BusWrite) rdata <= BusRData;
            end else if (timeout) begin
               BusReq <= 1'b0;
               rdata  <= '0;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
      end
   end

   always_comb begin
      lane_b = rdata[7:0];
      unique case (lo_q)
         2'b00: lane_b = rdata[7:0];
         2'b01: lane_b = rdata[15:8];
         2'b10: lane_b = rdata[23:16];
         2'b11: lane_b = rdata[31:24];
         default: lane_b = rdata[7:0];
      endcase
   end

   assign lane_h = lo_q[1] ? rdata[31:16] : rdata[15:0];

   always_comb begin
      ReadData = rdata;
      unique case (f3_q)
         3'b000:  ReadData = {{24{lane_b[7]}}, lane_b};
         3'b100:  ReadData = {24'b0, lane_b};
         3'b001:  ReadData = {{16{lane_h[15]}}, lane_h};
         3'b101:  ReadData = {16'b0, lane_h};
         default: ReadData = rdata;
      endcase
   end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: transaction-level model compared every cycle
// plus directed accesses with hand-computed results.
module tb_lsu;

   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [1:0]  MemRW = 2'b00;
   logic [2:0]  Funct3 = 3'b000;
   logic [31:0] IEUAdr = '0;
   logic [31:0] WriteData = '0;
   logic        BusAck = 1'b0;
   logic [31:0] BusRData = '0;

   logic [31:0] ReadData, BusAdr, BusWData;
   logic        Stall, LoadMisaligned, StoreMisaligned, AccessFault;
   logic        BusReq, BusWrite;
   logic [3:0]  BusByteEn;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   lsu #(.TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .MemRW(MemRW), .Funct3(Funct3),
      .IEUAdr(IEUAdr), .WriteData(WriteData), .ReadData(ReadData),
      .Stall(Stall), .LoadMisaligned(LoadMisaligned),
      .StoreMisaligned(StoreMisaligned), .AccessFault(AccessFault),
      .BusReq(BusReq), .BusWrite(BusWrite), .BusAdr(BusAdr),
      .BusByteEn(BusByteEn), .BusWData(BusWData), .BusAck(BusAck),
      .BusRData(BusRData)
   );

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic int sz(input logic [2:0] f);
      if (f[1:0] == 2'b00) return 1;
      if (f[1:0] == 2'b01) return 2;
      return 4;
   endfunction

   function automatic bit is_aligned(input logic [2:0] f,
                                     input logic [31:0] a);
      return (int'(a[1:0]) % sz(f)) == 0;
   endfunction

   function automatic logic [3:0] exp_be(input logic [2:0] f,
                                         input logic [31:0] a);
      int off;
      off = int'(a[1:0]);
      return 4'(((1 << sz(f)) - 1) << off);
   endfunction

   function automatic logic [31:0] exp_wd(input logic [2:0] f,
                                          input logic [31:0] wd);
      if (sz(f) == 1) return 32'(wd[7:0]) * 32'h01010101;
      if (sz(f) == 2) return 32'(wd[15:0]) * 32'h00010001;
      return wd;
   endfunction

   function automatic logic [31:0] fmt(input logic [2:0] f,
                                       input logic [31:0] a,
                                       input logic [31:0] r);
      logic [31:0] v;
      v = r >> (8 * int'(a[1:0]));
      if (sz(f) == 1) begin
         v = v & 32'hFF;
         if (!f[2] && v >= 32'd128) v = v - 32'd256;
      end else if (sz(f) == 2) begin
         v = v & 32'hFFFF;
         if (!f[2] && v >= 32'd32768) v = v - 32'd65536;
      end else begin
         v = r;
      end
      return v;
   endfunction

   // Transaction model: 0 = no access, 1 = on the bus, 2 = retiring
   int          m_ph = 0;
   int          m_wait = 0;
   logic        m_wr = 1'b0;
   logic        m_fault = 1'b0;
   logic [2:0]  m_f3 = '0;
   logic [31:0] m_adr = '0;
   logic [31:0] m_wd = '0;
   logic [31:0] m_rd = '0;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_ph <= 0; m_wait <= 0; m_wr <= 1'b0; m_fault <= 1'b0;
         m_f3 <= '0; m_adr <= '0; m_wd <= '0; m_rd <= '0;
      end else begin
         m_fault <= 1'b0;
         if (m_ph == 0) begin
            if ((MemRW == 2'b01 || MemRW == 2'b10)
                && is_aligned(Funct3, IEUAdr)) begin
               m_ph <= 1; m_wait <= 0; m_wr <= (MemRW == 2'b01);
               m_f3 <= Funct3; m_adr <= IEUAdr; m_wd <= WriteData;
            end
         end else if (m_ph == 1) begin
            if (BusAck) begin
               m_ph <= 2;
               if (!m_wr) m_rd <= BusRData;
            end else if (m_wait + 1 == TO) begin
               m_ph <= 2; m_rd <= '0; m_fault <= 1'b1;
            end else begin
               m_wait <= m_wait + 1;
            end
         end else begin
            m_ph <= 0;
         end
      end
   end

   logic c_acc, c_al;
   assign c_acc = reset && (m_ph == 0) && (MemRW == 2'b01 || MemRW == 2'b10);
   assign c_al  = is_aligned(Funct3, IEUAdr);

   always @(negedge clk) begin
      chk("m_stall", 32'(Stall), 32'((c_acc && c_al) || m_ph == 1));
      chk("m_busreq", 32'(BusReq), 32'(m_ph == 1));
      chk("m_loadmis", 32'(LoadMisaligned),
          32'(c_acc && !c_al && MemRW == 2'b10));
      chk("m_storemis", 32'(StoreMisaligned),
          32'(c_acc && !c_al && MemRW == 2'b01));
      chk("m_fault", 32'(AccessFault), 32'(m_fault));
      chk("m_readdata", ReadData, fmt(m_f3, m_adr, m_rd));
      if (m_ph == 1) begin
         chk("m_busadr", BusAdr, {m_adr[31:2], 2'b00});
         chk("m_buswrite", 32'(BusWrite), 32'(m_wr));
         chk("m_byteen", 32'(BusByteEn), 32'(exp_be(m_f3, m_adr)));
         chk("m_wdata", BusWData, exp_wd(m_f3, m_wd));
      end
   end

   int          r_stalls, r_busy;
   logic        r_wr, r_af, r_lm, r_sm, r_got;
   logic [31:0] r_rd, r_adr, r_wd;
   logic [3:0]  r_be;

   // Starts and ends just after a rising edge.
   task automatic run_access(input logic [1:0] rw, input logic [2:0] f3,
                             input logic [31:0] adr, input logic [31:0] wd,
                             input int waits, input logic [31:0] rd);
      bit done;
      MemRW = rw; Funct3 = f3; IEUAdr = adr; WriteData = wd;
      BusRData = rd; BusAck = 1'b0;
      r_stalls = 0; r_busy = 0; r_got = 1'b0; r_lm = 1'b0; r_sm = 1'b0;
      r_rd = '0; r_af = 1'b0; r_adr = '0; r_wd = '0; r_be = '0; r_wr = 1'b0;
      done = 1'b0;
      for (int c = 0; c < 100 && !done; c++) begin
         @(negedge clk);
         if (LoadMisaligned) r_lm = 1'b1;
         if (StoreMisaligned) r_sm = 1'b1;
         if (BusReq) begin
            r_busy++;
            if (!r_got) begin
               r_got = 1'b1; r_adr = BusAdr; r_wd = BusWData;
               r_be = BusByteEn; r_wr = BusWrite;
            end
            if (r_busy > waits) BusAck = 1'b1;
         end
         if (Stall) r_stalls++;
         else begin
            done = 1'b1; r_rd = ReadData; r_af = AccessFault;
         end
      end
      if (!done) begin
         failures++;
         $display("FAIL access_bound actual=stalled required=complete");
      end
      @(posedge clk); #1;
      MemRW = 2'b00; BusAck = 1'b0;
   endtask

   initial begin
      #1;
      reset = 1'b0; MemRW = 2'b10; Funct3 = 3'b010; IEUAdr = 32'h1000;
      @(negedge clk);
      chk("rst_stall", 32'(Stall), 32'd0);
      chk("rst_busreq", 32'(BusReq), 32'd0);
      chk("rst_busadr", BusAdr, 32'd0);
      chk("rst_byteen", 32'(BusByteEn), 32'd0);
      chk("rst_wdata", BusWData, 32'd0);
      chk("rst_readdata", ReadData, 32'd0);
      @(posedge clk); #1;
      reset = 1'b1; MemRW = 2'b00;
      @(posedge clk); #1;

      run_access(2'b10, 3'b010, 32'h1000, 32'h0, 2, 32'hDEADBEEF);
      chk("lw_adr", r_adr, 32'h1000);
      chk("lw_be", 32'(r_be), 32'hF);
      chk("lw_wr", 32'(r_wr), 32'd0);
      chk("lw_stalls", 32'(r_stalls), 32'd4);
      chk("lw_rd", r_rd, 32'hDEADBEEF);

      run_access(2'b01, 3'b000, 32'h2003, 32'h000000A5, 0, 32'h0);
      chk("sb_be", 32'(r_be), 32'h8);
      chk("sb_wd", r_wd, 32'hA5A5A5A5);
      chk("sb_adr", r_adr, 32'h2000);
      chk("sb_wr", 32'(r_wr), 32'd1);
      chk("sb_stalls", 32'(r_stalls), 32'd2);

      run_access(2'b01, 3'b001, 32'h2002, 32'h1234BEEF, 1, 32'h0);
      chk("sh_be", 32'(r_be), 32'hC);
      chk("sh_wd", r_wd, 32'hBEEFBEEF);

      run_access(2'b10, 3'b001, 32'h3002, 32'h0, 1, 32'h80FF1234);
      chk("lh_rd", r_rd, 32'hFFFF80FF);
      run_access(2'b10, 3'b101, 32'h3002, 32'h0, 0, 32'h80FF1234);
      chk("lhu_rd", r_rd, 32'h000080FF);
      run_access(2'b10, 3'b000, 32'h3001, 32'h0, 0, 32'h80FF1234);
      chk("lb_rd", r_rd, 32'h00000012);
      run_access(2'b10, 3'b000, 32'h3003, 32'h0, 3, 32'h80FF1234);
      chk("lb3_rd", r_rd, 32'hFFFFFF80);
      run_access(2'b10, 3'b100, 32'h3003, 32'h0, 0, 32'h80FF1234);
      chk("lbu3_rd", r_rd, 32'h00000080);

      run_access(2'b10, 3'b010, 32'h4001, 32'h0, 0, 32'h0);
      chk("lwmis_flag", 32'(r_lm), 32'd1);
      chk("lwmis_busy", 32'(r_busy), 32'd0);
      chk("lwmis_stalls", 32'(r_stalls), 32'd0);
      run_access(2'b01, 3'b001, 32'h4001, 32'h0, 0, 32'h0);
      chk("shmis_flag", 32'(r_sm), 32'd1);
      chk("shmis_busy", 32'(r_busy), 32'd0);

      run_access(2'b10, 3'b010, 32'h6000, 32'h0, 1000, 32'h55555555);
      chk("to_busy", 32'(r_busy), 32'd16);
      chk("to_fault", 32'(r_af), 32'd1);
      chk("to_rd", r_rd, 32'd0);
      chk("to_stalls", 32'(r_stalls), 32'd17);

      MemRW = 2'b10; Funct3 = 3'b010; IEUAdr = 32'h5000; BusAck = 1'b0;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      #2 reset = 1'b0;
      #1;
      chk("mr_busreq", 32'(BusReq), 32'd0);
      chk("mr_stall", 32'(Stall), 32'd0);
      MemRW = 2'b00;
      @(posedge clk);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      run_access(2'b10, 3'b010, 32'h5004, 32'h0, 1, 32'h12345678);
      chk("mr_lw_rd", r_rd, 32'h12345678);
      chk("mr_lw_stalls", 32'(r_stalls), 32'd3);

      @(posedge clk); #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/lsu.md
Name: lsu

Overview:
- Load/store unit directly downstream of the integer datapath.
- Consumes the datapath's IEUAdr, WriteData and Funct3, and returns the formatted ReadData that feeds the datapath result mux.
- Drives a single-outstanding request/acknowledge data bus with arbitrary wait states, and stalls the core until the access completes.
- Handles byte/halfword lane steering, load sign/zero extension, misalignment detection and a bus-timeout access fault.

Parameters:
TIMEOUT, 16, BUSY cycles without BusAck before the access is aborted as a fault (≥2).

Ports:
clk  input  1  clock
reset  input  1  asynchronous active-low reset (asserted when 0)
MemRW  input  2  10 load, 01 store, 00/11 no access
Funct3  input  3  access size/sign (RISC-V encoding)
IEUAdr  input  32  byte address from datapath
WriteData  input  32  store data (rs2) from datapath
ReadData  output  32  formatted load result to datapath
Stall  output  1  hold PC/instruction this cycle
LoadMisaligned  output  1  one-cycle fault pulse
StoreMisaligned  output  1  one-cycle fault pulse
AccessFault  output  1  one-cycle fault pulse (timeout)
BusReq  output  1  request valid
BusWrite  output  1  1 store, 0 load
BusAdr  output  32  word-aligned address ({IEUAdr[31:2],2'b00})
BusByteEn  output  4  byte lane enables
BusWData  output  32  lane-replicated store data
BusAck  input  1  completion; valid only while BusReq=1
BusRData  input  32  load data, valid with BusAck

Behaviour:
- FSM states: IDLE, BUSY, DONE. All state is registered.
- Reset: asynchronous to IDLE. BusReq, BusWrite, BusAdr, BusByteEn, BusWData, the read-data register, the fault outputs and the timeout counter all reset to 0. Stall is forced to 0 while reset=0.
- Aligned, defined as:
  - byte: always aligned;
  - half (Funct3[1:0]=01): requires IEUAdr[0]=0;
  - word (all other Funct3): requires IEUAdr[1:0]=00.
- IDLE:
  - MemRW∈{01,10} and aligned: Stall=1 combinationally. At the next edge, register BusAdr, BusWrite, BusByteEn, BusWData and Funct3/IEUAdr[1:0]; set BusReq=1; clear the counter; go to BUSY.
  - Access requested but misaligned: no bus access and Stall=0. The matching fault output is 1 for exactly that cycle (combinational from inputs).
- BUSY:
  - Stall=1. BusReq and all bus outputs are held stable.
  - BusAck=1: capture BusRData (loads); BusReq=0 at the edge; go to DONE.
  - Otherwise, counter increments. When the counter reaches TIMEOUT-1 without an ack: BusReq=0, read register=0, AccessFault=1 in DONE, go to DONE.
  - An ack arriving in the same cycle as the timeout wins; no fault.
- DONE:
  - Stall=0, so the core retires the instruction.
  - ReadData is valid. AccessFault is high only if the access timed out.
  - Unconditionally returns to IDLE; the still-present MemRW is ignored, so there is no relaunch.
- Minimum access latency: 3 cycles (IDLE, BUSY with ack, DONE). Each wait state adds 1.
- Byte enables:
  - byte: 0001<<IEUAdr[1:0];
  - half: 0011<<{IEUAdr[1],1'b0};
  - word: 1111.
- Store data:
  - byte: {4{WriteData[7:0]}};
  - half: {2{WriteData[15:0]}};
  - word: WriteData.
- Load format: from the registered data, select the lane using the registered address bits.
  - 000 lb: sign-extend.
  - 100 lbu: zero-extend.
  - 001 lh: sign-extend.
  - 101 lhu: zero-extend.
  - Other encodings: full word.
- ReadData outside DONE: the formatted value of the read register. This is don't-care to the core, but it is deterministic.
- BusAck while BusReq=0 is ignored.
- Reset deasserted mid-access is not defined. Reset asserted mid-access drops BusReq immediately; the bus must tolerate an abandoned request.

Test Plan:
- lw, IEUAdr=0x1000, BusAck after 2 wait cycles, BusRData=0xDEADBEEF:
  - BusAdr=0x1000, BusByteEn=1111, BusWrite=0.
  - Stall=1 for 4 cycles.
  - ReadData=0xDEADBEEF in DONE.
- sb, IEUAdr=0x2003, WriteData=0x000000A5, immediate ack: BusByteEn=1000, BusWData=0xA5A5A5A5, BusAdr=0x2000, BusWrite=1, Stall=1 for 2 cycles.
- Loads at 0x3002 with BusRData=0x80FF1234:
  - lh → 0xFFFF80FF;
  - lhu → 0x000080FF;
  - lb at 0x3001 → 0x00000012.
- Misaligned accesses:
  - lw at 0x4001: LoadMisaligned=1 for one cycle, BusReq never asserted, Stall=0.
  - sh at 0x4001: StoreMisaligned=1.
- Timeout: lw with BusAck held 0 and TIMEOUT=16 → BusReq drops after 16 BUSY cycles, DONE with AccessFault=1, ReadData=0, Stall released.
- Reset mid-BUSY: reset=0 in the second wait cycle → BusReq=0 and Stall=0 immediately, state IDLE. After release, a fresh lw completes normally.
